memshare_port_sched: RTL

Round-robin scheduler that shares one physical single-port memory among VIRTUAL_NUM virtual requesters. Each requester presents a read or write command with a request/grant handshake. The block issues at most one command per cycle to the physical port and routes read data back to the requester that issued the read. It sits between the layer-decoder message-update engines and one shared-memory bank, and it sequences the bank's time-multiplexed access.

---
 rtl/memshare_pkg.sv | 32 +++
 rtl/memshare_port_sched_arbiter.sv | 87 ++++++++
 rtl/memshare_port_sched.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/memshare_pkg.sv
// memshare_pkg
// Shared definitions for the shared-memory port scheduler:
//   - default requester count and physical read latency
//   - id_width(): requester-id width, clog2 with a floor of 1 bit
//   - tag_t: read-return tag {valid, requester id} carried down the
//     read-latency pipeline
package memshare_pkg;

    localparam int DEF_VIRTUAL_NUM = 2;
    localparam int DEF_RD_LAT      = 1;

    // Requester-id width; a 2-requester system still needs one bit.
    function automatic int id_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

    localparam int ID_BITWIDTH = id_width(DEF_VIRTUAL_NUM);

    // Tag id field is sized generously so that the top can be built with
    // more requesters than the package default without touching the struct.
    localparam int TAG_ID_BITWIDTH = 8;

    typedef struct packed {
        logic                       valid;
        logic [TAG_ID_BITWIDTH-1:0] id;
    } tag_t;

endpackage

// File: rtl/memshare_port_sched_arbiter.sv
// memshare_rr_arbiter
// Round-robin arbiter: searches upward from rr_ptr (with wrap) for the
// first active request. The grant is combinational; rr_ptr advances to
// (granted index + 1) mod VIRTUAL_NUM on every transfer and holds otherwise.
// Ports:
//   clk_i      clock
//   rstn_i     synchronous active-low reset (also masks the grant)
//   en_i       grant enable
//   req_i      per-requester request
//   gnt_o      one-hot grant
//   gnt_idx_o  index of the granted requester (valid when xfer_o=1)
//   xfer_o     a command transfers this cycle
module memshare_rr_arbiter
    import memshare_pkg::*;
#(
    parameter int VIRTUAL_NUM = DEF_VIRTUAL_NUM,
    localparam int IDW        = id_width(VIRTUAL_NUM)
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   en_i,
    input  logic [VIRTUAL_NUM-1:0] req_i,
    output logic [VIRTUAL_NUM-1:0] gnt_o,
    output logic [IDW-1:0]         gnt_idx_o,
    output logic                   xfer_o
);

    logic [IDW-1:0]         rr_ptr_q;
    logic [IDW-1:0]         rr_ptr_d;
    logic [IDW-1:0]         cand_s;
    logic [IDW-1:0]         idx_s;
    logic [VIRTUAL_NUM-1:0] gnt_s;
    logic                   found_s;

    // Priority search starting at rr_ptr, wrapping modulo VIRTUAL_NUM.
    always_comb begin
        gnt_s   = '0;
        idx_s   = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int i = 0; i < VIRTUAL_NUM; i++) begin
            cand_s = IDW'((int'(rr_ptr_q) + i) % VIRTUAL_NUM);
            if (!found_s && req_i[cand_s]) begin
                found_s       = 1'b1;
                gnt_s[cand_s] = 1'b1;
                idx_s         = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Grant is suppressed while disabled or held in reset.
    always_comb begin
        if (en_i && rstn_i) begin
            gnt_o = gnt_s;
        end else begin
            gnt_o = '0;
        end
    end

    assign gnt_idx_o = idx_s;
    assign xfer_o    = |gnt_o;

    // Next pointer: one past the winner on a transfer, otherwise hold.
    always_comb begin
        if (xfer_o) begin
            if (idx_s == IDW'(VIRTUAL_NUM - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = idx_s + IDW'(1);
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/memshare_port_sched.sv
// memshare_port_sched
// Shares one single-port memory among VIRTUAL_NUM requesters. One command
// per cycle is granted round-robin, registered onto the physical port, and
// read data is steered back to the issuing requester via a tag pipeline
// that tracks the physical read latency.
// Ports:
//   sys_clk, rstn                   clock, synchronous active-low reset
//   sched_en_i                      0 = no new grants (in-flight reads finish)
//   vir_req_i/we_i/addr_i/wdata_i   per-requester command (flattened slices)
//   vir_gnt_o                       one-hot combinational grant
//   vir_rvalid_o, vir_rdata_o       registered read return
//   phy_en_o/we_o/addr_o/din_o      registered physical command
//   phy_dout_i                      physical read data, RD_LAT after phy_en_o
//   busy_o                          access issued or read still in flight
module memshare_port_sched
    import memshare_pkg::*;
#(
    parameter int VIRTUAL_NUM   = DEF_VIRTUAL_NUM,
    parameter int PORT_BITWIDTH = 5,
    parameter int ADDR_BITWIDTH = 6,
    parameter int RD_LAT        = DEF_RD_LAT
) (
    input  logic                                 sys_clk,
    input  logic                                 rstn,
    input  logic                                 sched_en_i,
    input  logic [VIRTUAL_NUM-1:0]               vir_req_i,
    input  logic [VIRTUAL_NUM-1:0]               vir_we_i,
    input  logic [VIRTUAL_NUM*ADDR_BITWIDTH-1:0] vir_addr_i,
    input  logic [VIRTUAL_NUM*PORT_BITWIDTH-1:0] vir_wdata_i,
    output logic [VIRTUAL_NUM-1:0]               vir_gnt_o,
    output logic [VIRTUAL_NUM-1:0]               vir_rvalid_o,
    output logic [PORT_BITWIDTH-1:0]             vir_rdata_o,
    output logic                                 phy_en_o,
    output logic                                 phy_we_o,
    output logic [ADDR_BITWIDTH-1:0]             phy_addr_o,
    output logic [PORT_BITWIDTH-1:0]             phy_din_o,
    input  logic [PORT_BITWIDTH-1:0]             phy_dout_i,
    output logic                                 busy_o
);

    localparam int IDW = id_width(VIRTUAL_NUM);

    logic [IDW-1:0]           gnt_idx_s;
    logic                     xfer_s;

    logic                     phy_en_q,   phy_en_d;
    logic                     phy_we_q,   phy_we_d;
    logic [ADDR_BITWIDTH-1:0] phy_addr_q, phy_addr_d;
    logic [PORT_BITWIDTH-1:0] phy_din_q,  phy_din_d;
    tag_t                     tag_q [RD_LAT+1];
    tag_t                     tag_in_s;
    logic [VIRTUAL_NUM-1:0]   rvalid_q, rvalid_d;
    logic [PORT_BITWIDTH-1:0] rdata_q,  rdata_d;
    logic                     tag_busy_s;
    logic                     sel_we_s;

    memshare_rr_arbiter #(
        .VIRTUAL_NUM (VIRTUAL_NUM)
    ) u_arb (
        .clk_i     (sys_clk),
        .rstn_i    (rstn),
        .en_i      (sched_en_i),
        .req_i     (vir_req_i),
        .gnt_o     (vir_gnt_o),
        .gnt_idx_o (gnt_idx_s),
        .xfer_o    (xfer_s)
    );

    assign sel_we_s = vir_we_i[gnt_idx_s];

    // Issue stage next-state: capture the granted slice on a transfer;
    // addr/din hold when idle so the port does not toggle needlessly.
    always_comb begin
        phy_en_d = xfer_s;
        if (xfer_s) begin
            phy_we_d   = sel_we_s;
            phy_addr_d = vir_addr_i[int'(gnt_idx_s)*ADDR_BITWIDTH +: ADDR_BITWIDTH];
            phy_din_d  = vir_wdata_i[int'(gnt_idx_s)*PORT_BITWIDTH +: PORT_BITWIDTH];
        end else begin
            phy_we_d   = 1'b0;
            phy_addr_d = phy_addr_q;
            phy_din_d  = phy_din_q;
        end
        tag_in_s.valid = xfer_s & ~sel_we_s;
        tag_in_s.id    = TAG_ID_BITWIDTH'(gnt_idx_s);
    end

    // Return stage next-state: the last tag stage lines up with phy_dout_i.
    always_comb begin
        rvalid_d = '0;
        if (tag_q[RD_LAT].valid) begin
            for (int k = 0; k < VIRTUAL_NUM; k++) begin
                rvalid_d[k] = (tag_q[RD_LAT].id == TAG_ID_BITWIDTH'(k));
            end
            rdata_d = phy_dout_i;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // OR of all in-flight read tags.
    always_comb begin
        tag_busy_s = 1'b0;
        for (int k = 0; k <= RD_LAT; k++) begin
            tag_busy_s = tag_busy_s | tag_q[k].valid;
        end
    end

    // Issue registers, tag pipeline and return registers.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            phy_en_q   <= 1'b0;
            phy_we_q   <= 1'b0;
            phy_addr_q <= '0;
            phy_din_q  <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
            for (int k = 0; k <= RD_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            phy_en_q   <= phy_en_d;
            phy_we_q   <= phy_we_d;
            phy_addr_q <= phy_addr_d;
            phy_din_q  <= phy_din_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            tag_q[0]   <= tag_in_s;
            for (int k = 1; k <= RD_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign phy_en_o     = phy_en_q;
    assign phy_we_o     = phy_we_q;
    assign phy_addr_o   = phy_addr_q;
    assign phy_din_o    = phy_din_q;
    assign vir_rvalid_o = rvalid_q;
    assign vir_rdata_o  = rdata_q;
    assign busy_o       = phy_en_q | tag_busy_s | (|rvalid_q);

endmodule
